// File: rtl/half_adder_pkg.sv
// Shared types and constants for the registered half-adder slice.
// The optional carry counter is enabled by the HALF_ADDER_CARRY_COUNT_EN macro.
package half_adder_pkg;

  localparam int CNT_W = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = 16'hFFFF;

  // Increment that sticks at the top value instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == CNT_MAX) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Combinational 1-bit half adder: s = a ^ b, c = a & b.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/half_adder.sv
// Registered bit-slice half adder with WIDTH independent lanes and one cycle of latency.
// Defining HALF_ADDER_CARRY_COUNT_EN adds a saturating count of carry-generating inputs.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
`ifdef HALF_ADDER_CARRY_COUNT_EN
  ,
  output cnt_t             carry_count
`endif
);

  // Handshake: in_valid qualifies a/b for one edge; there is no ready, every
  // valid input is accepted and out_valid pulses exactly one cycle later.

  logic [WIDTH-1:0] s_w;
  logic [WIDTH-1:0] c_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a (a[i]),
      .b (b[i]),
      .s (s_w[i]),
      .c (c_w[i])
    );
  end

  // sum/carry only load on accepted inputs so idle-cycle junk on a/b is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= s_w;
        carry <= c_w;
      end
    end
  end

`ifdef HALF_ADDER_CARRY_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_count <= '0;
    end else if (in_valid && (|c_w)) begin
      carry_count <= sat_inc(carry_count);
    end
  end
`endif

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: a WIDTH=4 and a WIDTH=1 instance driven side by side,
// checked against a per-lane arithmetic model (sum + 2*carry == a + b).
module tb_half_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a4, b4, sum4, carry4;
  logic       a1, b1, sum1, carry1;
  logic       ov4, ov1;
`ifdef HALF_ADDER_CARRY_COUNT_EN
  logic [15:0] cc4, cc1;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Scoreboard: one packed expectation per cycle {ov4, sum4, carry4, ov1, sum1, carry1}.
  logic [11:0] exp_q[$];

  // Reference model state.
  logic [3:0] m_sum4, m_carry4;
  logic       m_sum1, m_carry1, m_v;
  int         m_cnt4, m_cnt1;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a4),
    .b         (b4),
    .out_valid (ov4),
    .sum       (sum4),
    .carry     (carry4)
`ifdef HALF_ADDER_CARRY_COUNT_EN
    ,
    .carry_count (cc4)
`endif
  );

  half_adder #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a1),
    .b         (b1),
    .out_valid (ov1),
    .sum       (sum1),
    .carry     (carry1)
`ifdef HALF_ADDER_CARRY_COUNT_EN
    ,
    .carry_count (cc1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one edge using plain per-lane arithmetic.
  task automatic model_edge(input logic r, input logic v,
                            input logic [3:0] ia4, input logic [3:0] ib4,
                            input logic ia1, input logic ib1);
    int  t;
    bit  any4;
    if (r) begin
      m_v = 0; m_sum4 = '0; m_carry4 = '0; m_sum1 = 0; m_carry1 = 0;
      m_cnt4 = 0; m_cnt1 = 0;
    end else begin
      m_v = v;
      if (v) begin
        any4 = 0;
        for (int i = 0; i < 4; i++) begin
          t = int'(ia4[i]) + int'(ib4[i]);
          m_sum4[i]   = (t % 2) != 0;
          m_carry4[i] = (t / 2) != 0;
          if (t == 2) any4 = 1;
        end
        t = int'(ia1) + int'(ib1);
        m_sum1   = (t % 2) != 0;
        m_carry1 = (t / 2) != 0;
        if (any4) m_cnt4++;
        if (t == 2) m_cnt1++;
      end
    end
    exp_q.push_back({m_v, m_sum4, m_carry4, m_v, m_sum1, m_carry1});
  endtask

  // Drive one cycle; outputs are sampled on the falling edge after the active edge.
  task automatic step(input logic r, input logic v,
                      input logic [3:0] ia4, input logic [3:0] ib4,
                      input logic ia1, input logic ib1, input bit do_check);
    logic [11:0] e;
    rst = r; in_valid = v; a4 = ia4; b4 = ib4; a1 = ia1; b1 = ib1;
    @(posedge clk);
    model_edge(r, v, ia4, ib4, ia1, ib1);
    @(negedge clk);
    e = exp_q.pop_front();
    if (do_check) begin
      check("ov4",    32'(ov4),    32'(e[11]));
      check("sum4",   32'(sum4),   32'(e[10:7]));
      check("carry4", 32'(carry4), 32'(e[6:3]));
      check("ov1",    32'(ov1),    32'(e[2]));
      check("sum1",   32'(sum1),   32'(e[1]));
      check("carry1", 32'(carry1), 32'(e[0]));
      check("inv4",   32'(sum4 & carry4), 32'(0));
      check("inv1",   32'(sum1 & carry1), 32'(0));
`ifdef HALF_ADDER_CARRY_COUNT_EN
      check("cnt4", 32'(cc4), 32'((m_cnt4 > 65535) ? 65535 : m_cnt4));
      check("cnt1", 32'(cc1), 32'((m_cnt1 > 65535) ? 65535 : m_cnt1));
`endif
    end
  endtask

  initial begin
    logic [1:0] k;
    rst = 1'b1; in_valid = 1'b0; a4 = '0; b4 = '0; a1 = 1'b0; b1 = 1'b0;
    m_v = 0; m_sum4 = '0; m_carry4 = '0; m_sum1 = 0; m_carry1 = 0; m_cnt4 = 0; m_cnt1 = 0;
    @(negedge clk);

    // Reset held two cycles with all-ones valid input: outputs must stay cleared.
    step(1, 1, 4'hF, 4'hF, 1, 1, 1);
    step(1, 1, 4'hF, 4'hF, 1, 1, 1);
    check("rst_sum4", 32'(sum4), 32'(0));
    check("rst_ov4",  32'(ov4),  32'(0));

    // Exhaustive scalar truth table, back to back.
    for (int i = 0; i < 4; i++) begin
      k = 2'(i);
      step(0, 1, 4'(i * 5), 4'(i * 3), k[1], k[0], 1);
    end
    check("tt_last_carry1", 32'(carry1), 32'(1));

    // Hold: idle cycle with a=b=1 must not disturb the stored result.
    step(0, 1, 4'b0001, 4'b0000, 1, 0, 1);
    step(0, 0, 4'b1111, 4'b1111, 1, 1, 1);
    check("hold_sum1", 32'(sum1), 32'(1));
    check("hold_ov1",  32'(ov1),  32'(0));

    // Directed multi-lane vector.
    step(0, 1, 4'b1100, 4'b1010, 0, 0, 1);
    check("dir_sum4",   32'(sum4),   32'(4'b0110));
    check("dir_carry4", 32'(carry4), 32'(4'b1000));

    // Reset arriving with a valid input discards it.
    step(0, 1, 4'hF, 4'hF, 1, 1, 1);
    step(1, 1, 4'hF, 4'hF, 1, 1, 1);
    check("mid_rst_carry4", 32'(carry4), 32'(0));

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), 1'($urandom), 4'($urandom), 4'($urandom),
           1'($urandom), 1'($urandom), 1);
    end

`ifdef HALF_ADDER_CARRY_COUNT_EN
    // Three accepted inputs, two generating carry.
    step(1, 0, 4'h0, 4'h0, 0, 0, 1);
    step(0, 1, 4'b0011, 4'b0001, 1, 1, 1);
    step(0, 1, 4'b0101, 4'b1010, 1, 0, 1);
    step(0, 1, 4'b1000, 4'b1000, 1, 1, 1);
    check("cnt_dir4", 32'(cc4), 32'(2));

    // Drive past the top value; the counter must stick at 16'hFFFF.
    for (int i = 0; i < 65540; i++) step(0, 1, 4'hF, 4'hF, 1, 1, 0);
    step(0, 1, 4'hF, 4'hF, 1, 1, 1);
    check("cnt_sat4", 32'(cc4), 32'(16'hFFFF));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
